spm_seq_mult: RTL and testbench

Parametrised serial-parallel multiplier for the spm datapath. It generalises the single fixed-width CSA chain into a WIDTH-bit unsigned multiplier with a valid/ready operand and result handshake. It accepts parallel operands x and y, streams y LSB-first through an array of carry-save cells over 2·WIDTH cycles, and returns the full 2·WIDTH-bit product. It sits between the operand front-end and the result collector, and replaces the hard-wired spm top.

---
 rtl/spm_pkg.sv | 7 +
 rtl/spm_csa_cell.sv | 25 ++
 rtl/spm_seq_mult.sv | 79 +++++++
 tb/tb_spm_seq_mult.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/spm_pkg.sv
// spm_pkg: shared state encoding and sizing helpers for the serial-parallel multiplier.
package spm_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} spm_state_e;
  function automatic int cnt_w(input int width);
    return $clog2(2 * width);
  endfunction
endpackage

// File: rtl/spm_csa_cell.sv
// spm_csa_cell: one carry-save bit of the serial-parallel multiplier array.
module spm_csa_cell (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic a,
  input  logic b,
  output logic s,
  output logic sr_q,
  output logic cr_q
);
  assign s = a ^ b ^ cr_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= 1'b0;
      cr_q <= 1'b0;
    end else if (clr_i) begin
      sr_q <= 1'b0;
      cr_q <= 1'b0;
    end else begin
      sr_q <= s;
      cr_q <= (a & b) | (a & cr_q) | (b & cr_q);
    end
  end
endmodule

// File: rtl/spm_seq_mult.sv
// spm_seq_mult: WIDTH-bit unsigned serial-parallel multiplier with valid/ready handshakes.
module spm_seq_mult
  import spm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
);
  localparam int CW = cnt_w(WIDTH);
  spm_state_e         r_state, w_next;
  logic [WIDTH-1:0]   r_x, r_y, w_s, w_yshift, w_unused_cr;
  logic [WIDTH:0]     w_sr;
  logic [2*WIDTH-1:0] r_p;
  logic [CW-1:0]      r_cnt;
  logic               w_accept, w_last, w_ybit, w_clr_cells, w_unused;
  assign in_ready    = r_state == IDLE;
  assign out_valid   = r_state == DONE;
  assign p           = r_p;
  assign w_accept    = !clr && in_valid && r_state == IDLE;
  assign w_last      = r_cnt == CW'(2 * WIDTH - 1);
  // shifting past the operand width naturally yields zeros for the flush phase
  assign w_yshift    = r_y >> r_cnt;
  assign w_ybit      = (r_state == RUN) & w_yshift[0];
  assign w_clr_cells = w_accept | clr;
  assign w_sr[WIDTH] = 1'b0;
  assign w_unused    = ^{w_s[WIDTH-1:1], w_unused_cr};
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    spm_csa_cell u_cell (
      .clk   (clk),
      .rst   (rst),
      .clr_i (w_clr_cells),
      .a     (r_x[i] & w_ybit),
      .b     (w_sr[i+1]),
      .s     (w_s[i]),
      .sr_q  (w_sr[i]),
      .cr_q  (w_unused_cr[i])
    );
  end
  always_comb begin
    w_next = clr                             ? IDLE :
             (r_state == IDLE && in_valid)   ? RUN  :
             (r_state == RUN  && w_last)     ? DONE :
             (r_state == DONE && out_ready)  ? IDLE : r_state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x   <= '0;
      r_y   <= '0;
      r_p   <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_x   <= x;
      r_y   <= y;
      r_p   <= '0;
      r_cnt <= '0;
    end else if (clr) begin
      r_x   <= '0;
      r_y   <= '0;
      r_p   <= '0;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_p   <= {w_s[0], r_p[2*WIDTH-1:1]};
      r_cnt <= r_cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_spm_seq_mult.sv
// tb_spm_seq_mult: directed checks of spm_seq_mult at WIDTH=8 and WIDTH=32.
module tb_spm_seq_mult;
  logic clk = 1'b0;
  logic rst, clr;
  logic iv8, ir8, ov8, or8;
  logic [7:0] x8, y8;
  logic [15:0] p8;
  logic iv32, ir32, ov32, or32;
  logic [31:0] x32, y32;
  logic [63:0] p32;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spm_seq_mult #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(iv8), .in_ready(ir8),
    .x(x8), .y(y8), .out_valid(ov8), .out_ready(or8), .p(p8)
  );
  spm_seq_mult #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(iv32), .in_ready(ir32),
    .x(x32), .y(y32), .out_valid(ov32), .out_ready(or32), .p(p32)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents operands until the accept edge; k = edges waited for in_ready.
  task automatic go8(input logic [7:0] a, input logic [7:0] b, output int k);
    k = 0;
    x8 = a; y8 = b; iv8 = 1'b1;
    while (!ir8 && k < 50) begin tick(); k++; end
    tick();
    iv8 = 1'b0; x8 = 8'h5A; y8 = 8'hC3;
  endtask

  // lat counts edges with the accept edge as 1; bad flags in_ready seen high.
  task automatic wait8(output int lat, output logic bad);
    lat = 1; bad = 1'b0;
    while (!ov8 && lat < 100) begin
      if (ir8) bad = 1'b1;
      tick(); lat++;
    end
  endtask

  task automatic go32(input logic [31:0] a, input logic [31:0] b);
    int k = 0;
    x32 = a; y32 = b; iv32 = 1'b1;
    while (!ir32 && k < 50) begin tick(); k++; end
    tick();
    iv32 = 1'b0; x32 = 32'hDEAD_0000; y32 = 32'h0000_BEEF;
  endtask

  task automatic wait32(output int lat);
    lat = 1;
    while (!ov32 && lat < 200) begin tick(); lat++; end
  endtask

  task automatic job32(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    int lat;
    int hold;
    or32 = 1'b0;
    go32(a, b);
    wait32(lat);
    chk("w32_latency", 64'(lat), 64'd65);
    chk("w32_product", p32, exp);
    hold = $urandom_range(0, 3);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("w32_hold", {ov32, p32}, {1'b1, exp});
    end
    or32 = 1'b1;
    tick();
    or32 = 1'b0;
    chk("w32_release", {ov32, ir32}, {1'b0, 1'b1});
  endtask

  initial begin
    int k, lat;
    logic bad;
    logic [31:0] ra, rb;
    rst = 1'b1; clr = 1'b0;
    iv8 = 1'b0; x8 = '0; y8 = '0; or8 = 1'b1;
    iv32 = 1'b0; x32 = '0; y32 = '0; or32 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset8", {ir8, ov8, p8}, {1'b1, 1'b0, 16'h0000});
    chk("reset32", {ir32, ov32, p32}, {1'b1, 1'b0, 64'h0});

    go8(8'hFF, 8'hFF, k);
    wait8(lat, bad);
    chk("ff_latency", 64'(lat), 64'd17);
    chk("ff_ready_low_run", 64'(bad), 64'd0);
    chk("ff_product", {ov8, ir8, p8}, {1'b1, 1'b0, 16'hFE01});
    tick();
    chk("ff_release", {ov8, ir8}, {1'b0, 1'b1});

    go8(8'h00, 8'hA5, k);
    wait8(lat, bad);
    chk("zero_product", {ov8, p8}, {1'b1, 16'h0000});
    go8(8'h01, 8'hFF, k);
    chk("b2b_gap", 64'(k), 64'd1);
    wait8(lat, bad);
    chk("b2b_latency", 64'(lat), 64'd17);
    chk("b2b_product", {ov8, p8}, {1'b1, 16'h00FF});
    tick();

    or8 = 1'b0;
    go8(8'h0D, 8'h0B, k);
    wait8(lat, bad);
    chk("bp_product", {ov8, p8}, {1'b1, 16'h008F});
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold", {ov8, ir8, p8}, {1'b1, 1'b0, 16'h008F});
    end
    or8 = 1'b1;
    tick();
    chk("bp_release", {ov8, ir8}, {1'b0, 1'b1});

    go8(8'h77, 8'h99, k);
    for (int i = 0; i < 5; i++) tick();
    clr = 1'b1; iv8 = 1'b1; x8 = 8'hAA; y8 = 8'hBB;
    tick();
    clr = 1'b0; iv8 = 1'b0;
    chk("clr_state", {ir8, ov8, p8}, {1'b1, 1'b0, 16'h0000});
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ov8 || !ir8) bad = 1'b1;
      tick();
    end
    chk("clr_no_output", 64'(bad), 64'd0);
    go8(8'h03, 8'h05, k);
    wait8(lat, bad);
    chk("clr_next_latency", 64'(lat), 64'd17);
    chk("clr_next_product", {ov8, p8}, {1'b1, 16'h000F});
    tick();

    go8(8'hFF, 8'hFF, k);
    for (int i = 0; i < 6; i++) tick();
    #2 rst = 1'b1;
    #1 chk("async_rst", {ir8, ov8, p8}, {1'b1, 1'b0, 16'h0000});
    #1 rst = 1'b0;
    tick();
    go8(8'h80, 8'h80, k);
    wait8(lat, bad);
    chk("rst_next_product", {ov8, p8}, {1'b1, 16'h4000});
    tick();

    job32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    job32(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    job32(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
    job32(32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE);
    job32(32'h0000_0000, 32'hDEAD_BEEF, 64'h0);
    job32(32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780);
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      job32(ra, rb, 64'(ra) * 64'(rb));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
